// File: rtl/butterfly_pkg.sv
// Shared types for the butterfly stream sequencer:
// FSM state encoding and the datapath control pulse bundle.
package butterfly_pkg;

    typedef enum logic [3:0] {
        W_RE   = 4'd0,
        W_IM   = 4'd1,
        B_RE   = 4'd2,
        B_IM   = 4'd3,
        LMULT  = 4'd4,
        A_RE   = 4'd5,
        MULT2  = 4'd6,
        A_IM   = 4'd7,
        SETTLE = 4'd8,
        OUT    = 4'd9
    } state_t;

    typedef struct packed {
        logic load_coeff;
        logic load_b;
        logic load_mult;
        logic multiply;
        logic load_output_reg;
        logic subtract;
        logic mult_out_select;
        logic fbr_input;
    } dp_ctrl_t;

    localparam dp_ctrl_t DP_CTRL_IDLE = '0;

endpackage

// File: rtl/butterfly_stream_sequencer.sv
// Streams W/B/A words into butterfly_datapath with registered one-cycle
// control pulses and returns Y_RE, Y_IM, Z_RE, Z_IM on an output stream.
module butterfly_stream_sequencer
    import butterfly_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               cfg_reload_w,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [DATA_W-1:0]  dp_data_in,
    input  logic [DATA_W-1:0]  dp_data_out,
    output logic               dp_load_coeff,
    output logic               dp_load_b,
    output logic               dp_load_mult,
    output logic               dp_multiply,
    output logic               dp_load_output_reg,
    output logic               dp_subtract,
    output logic               dp_mult_out_select,
    output logic               dp_fbr_input,
    output logic               busy,
    output logic [COUNT_W-1:0] bfly_count
);

    state_t   state;
    dp_ctrl_t ctrl;
    logic [1:0] out_idx;
    logic in_acc;
    logic out_acc;

    assign in_ready = state inside {W_RE, W_IM, B_RE, B_IM, A_RE, A_IM};
    assign out_valid = (state == OUT);
    assign busy = !(state inside {W_RE, B_RE});
    assign out_data = dp_data_out;

    assign in_acc  = in_valid & in_ready;
    assign out_acc = out_valid & out_ready;

    assign dp_load_coeff      = ctrl.load_coeff;
    assign dp_load_b          = ctrl.load_b;
    assign dp_load_mult       = ctrl.load_mult;
    assign dp_multiply        = ctrl.multiply;
    assign dp_load_output_reg = ctrl.load_output_reg;
    assign dp_subtract        = ctrl.subtract;
    assign dp_mult_out_select = ctrl.mult_out_select;
    assign dp_fbr_input       = ctrl.fbr_input;

    // Pulses fall back to idle every cycle; a branch raises them for one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= W_RE;
            ctrl       <= DP_CTRL_IDLE;
            dp_data_in <= '0;
            out_idx    <= '0;
            bfly_count <= '0;
        end else begin
            ctrl <= DP_CTRL_IDLE;
            case (state)
                W_RE: if (in_acc) begin
                    state <= W_IM;
                    dp_data_in <= in_data;
                    ctrl.load_coeff <= 1'b1;
                end
                W_IM: if (in_acc) begin
                    state <= B_RE;
                    dp_data_in <= in_data;
                    ctrl.load_coeff <= 1'b1;
                end
                B_RE: if (in_acc) begin
                    state <= B_IM;
                    dp_data_in <= in_data;
                    ctrl.load_b <= 1'b1;
                end
                B_IM: if (in_acc) begin
                    state <= LMULT;
                    dp_data_in <= in_data;
                    ctrl.load_b <= 1'b1;
                end
                LMULT: begin
                    state <= A_RE;
                    ctrl.load_b <= 1'b1;
                    ctrl.load_mult <= 1'b1;
                end
                A_RE: if (in_acc) begin
                    state <= MULT2;
                    dp_data_in <= in_data;
                    ctrl.fbr_input <= 1'b1;
                    ctrl.load_mult <= 1'b1;
                    ctrl.load_output_reg <= 1'b1;
                    ctrl.multiply <= 1'b1;
                    ctrl.subtract <= 1'b1;
                end
                MULT2: begin
                    state <= A_IM;
                    ctrl.multiply <= 1'b1;
                end
                A_IM: if (in_acc) begin
                    state <= SETTLE;
                    dp_data_in <= in_data;
                    ctrl.fbr_input <= 1'b1;
                    ctrl.load_output_reg <= 1'b1;
                    out_idx <= '0;
                end
                // One cycle for the datapath output register to show its update.
                SETTLE: state <= OUT;
                OUT: if (out_acc) begin
                    out_idx <= out_idx + 2'd1;
                    case (out_idx)
                        2'd0: begin
                            state <= SETTLE;
                            ctrl.load_output_reg <= 1'b1;
                            ctrl.mult_out_select <= 1'b1;
                        end
                        2'd1: begin
                            state <= SETTLE;
                            ctrl.load_output_reg <= 1'b1;
                            ctrl.subtract <= 1'b1;
                        end
                        2'd2: begin
                            state <= SETTLE;
                            ctrl.load_output_reg <= 1'b1;
                            ctrl.mult_out_select <= 1'b1;
                            ctrl.subtract <= 1'b1;
                        end
                        default: begin
                            state <= cfg_reload_w ? W_RE : B_RE;
                            bfly_count <= bfly_count + COUNT_W'(1);
                        end
                    endcase
                end
                default: state <= W_RE;
            endcase
        end
    end

endmodule
